// File: rtl/lut_eval_pkg.sv
// Shared constants, table-width helper and table type
// for the programmable LUT function evaluator.
package lut_eval_pkg;

  localparam int IN_W_DEF = 4;

  function automatic int tbl_w(input int in_w);
    return 1 << in_w;
  endfunction

  typedef logic [tbl_w(IN_W_DEF)-1:0] tbl_t;

endpackage

// File: rtl/lut_func_eval_if.sv
// Valid/ready stream bundle for the LUT evaluator:
// input vectors in, (f, idx) results out.
interface lut_func_eval_if
  import lut_eval_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) ();

  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_f;
  logic [IN_W-1:0] out_idx;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_f, out_idx
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_f, out_idx
  );

endinterface

// File: rtl/lut_onehot_dec.sv
// Combinational IN_W -> 2**IN_W one-hot decoder
// with enable; all-zero output when disabled.
module lut_onehot_dec
  import lut_eval_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic                    en,
  input  logic [IN_W-1:0]         idx,
  output logic [tbl_w(IN_W)-1:0]  oh
);

  always_comb begin
    oh = '0;
    if (en) oh[idx] = 1'b1;
  end

endmodule

// File: rtl/lut_func_eval.sv
// Two-stage programmable Boolean function evaluator.
// Optional saturating ones counter when CNT_EN is defined.
module lut_func_eval
  import lut_eval_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter logic [tbl_w(IN_W)-1:0] TABLE_INIT = '0
`ifdef CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lut_func_eval_if.slave         io,
  input  logic                   cfg_we,
  input  logic [IN_W-1:0]        cfg_addr,
  input  logic                   cfg_data,
  output logic [tbl_w(IN_W)-1:0] table_q
`ifdef CNT_EN
  , output logic [CNT_W-1:0]     ones_cnt,
  input  logic                   cnt_clr
`endif
);

  localparam int TW = tbl_w(IN_W);

  logic            s1_valid;
  logic            s2_valid;
  logic [IN_W-1:0] s1_data;
  logic            s1_ld;
  logic            s2_ld;
  logic [TW-1:0]   oh;

  assign s2_ld        = !s2_valid || io.out_ready;
  assign s1_ld        = !s1_valid || s2_ld;
  assign io.in_ready  = s1_ld;
  assign io.out_valid = s2_valid;

  lut_onehot_dec #(.IN_W(IN_W)) u_dec (
    .en  (s1_valid),
    .idx (s1_data),
    .oh  (oh)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (s1_ld) begin
      s1_valid <= io.in_valid;
      if (io.in_valid) s1_data <= io.in_data;
    end
  end

  // table_q here is the pre-write value when cfg_we hits the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      io.out_f   <= 1'b0;
      io.out_idx <= '0;
    end else if (s2_ld) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        io.out_idx <= s1_data;
        io.out_f   <= |(oh & table_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_q <= TABLE_INIT;
    end else if (cfg_we) begin
      table_q[cfg_addr] <= cfg_data;
    end
  end

`ifdef CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt <= '0;
    end else if (cnt_clr) begin
      ones_cnt <= '0;
    end else if (s2_valid && io.out_ready && io.out_f
                 && (ones_cnt != '1)) begin
      ones_cnt <= ones_cnt + 1'b1;
    end
  end
`endif

endmodule
